// File: rtl/gerador_pkg.sv
// Shared constants, state encoding and quarter-wave table generator for gerador_tom.
package gerador_pkg;

  localparam int PHASE_W_DEF = 24;
  localparam int ADDR_W      = 10;
  localparam int SAMPLE_W    = 12;
  localparam int LUT_DEPTH   = 256;
  localparam int MAG_W       = 11;
  localparam int IDX_W       = 8;
  localparam int MAG_MAX     = 2047;

  localparam real PI_HALF = 1.5707963267948966;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } estado_e;

  // Quarter-wave entry: round(2047*sin(pi/2*(i+0.5)/256)).
  // Sine is evaluated by a Taylor series so only basic real arithmetic is needed
  // at elaboration; on [0, pi/2] ten terms are far below the rounding step.
  function automatic logic [MAG_W-1:0] seno_lut(input int idx);
    real x;
    real term;
    real acc;
    x    = PI_HALF * (real'(idx) + 0.5) / real'(LUT_DEPTH);
    term = x;
    acc  = x;
    for (int k = 1; k < 10; k++) begin
      term = -term * x * x / real'((2 * k) * (2 * k + 1));
      acc  = acc + term;
    end
    return MAG_W'($rtoi(real'(MAG_MAX) * acc + 0.5));
  endfunction

endpackage

// File: rtl/tabela_seno.sv
// 256 x 11 quarter-wave sine magnitude ROM with a registered, read-enabled output.
module tabela_seno
  import gerador_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] idx,
  output logic [MAG_W-1:0] mag
);

  logic [MAG_W-1:0] rom [LUT_DEPTH];
  logic [MAG_W-1:0] mag_q;
  logic [MAG_W-1:0] mag_d;

  for (genvar g = 0; g < LUT_DEPTH; g++) begin : g_rom
    localparam logic [MAG_W-1:0] VAL = seno_lut(g);
    assign rom[g] = VAL;
  end

  // Read only when asked so the magnitude holds between samples.
  always_comb begin
    mag_d = mag_q;
    if (rd_en) begin
      mag_d = rom[idx];
    end
  end

  // Output register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mag_q <= '0;
    end else begin
      mag_q <= mag_d;
    end
  end

  assign mag = mag_q;

endmodule

// File: rtl/gerador_tom.sv
// DDS tone generator: phase accumulator stepped once every CLK_DIV clocks,
// quarter-wave ROM lookup with quadrant fold, signed 12-bit output.
//
// Increment handshake: a value transfers on a cycle where inc_valid and
// inc_ready are both 1. In IDLE it becomes the active increment on the next
// clock and inc_ready stays 1. In RUN it waits in a pending register
// (inc_ready = 0) and becomes active at the next tick, where it already drives
// that tick's accumulation; inc_ready returns the cycle after. inc_valid while
// inc_ready = 0 is dropped, nothing is queued.
module gerador_tom
  import gerador_pkg::*;
#(
  parameter int CLK_DIV = 50,
  parameter int PHASE_W = PHASE_W_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [PHASE_W-1:0]         fase_inc,
  input  logic                       inc_valid,
  output logic                       inc_ready,
  output logic signed [SAMPLE_W-1:0] saida,
  output logic                       amostra_pronta,
  output logic                       wrap,
  output estado_e                    estado_dbg
);

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] DIV_M1 = CNT_W'(CLK_DIV - 1);

  estado_e state_q, state_d;

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PHASE_W-1:0] acc_q, acc_d;
  logic [PHASE_W-1:0] inc_active_q, inc_active_d;
  logic [PHASE_W-1:0] pend_q, pend_d;
  logic               pend_vld_q, pend_vld_d;
  logic               carry_q, carry_d;

  logic               s1_vld_q, s1_vld_d;
  logic               s1_neg_q, s1_neg_d;
  logic               s1_wrap_q, s1_wrap_d;

  logic signed [SAMPLE_W-1:0] saida_q, saida_d;
  logic                       pronta_q, pronta_d;
  logic                       wrap_q, wrap_d;

  logic               tick;
  logic               run_next;
  logic               accept;
  logic [PHASE_W-1:0] inc_eff;
  logic [PHASE_W:0]   sum;
  logic [ADDR_W-1:0]  addr;
  logic [IDX_W-1:0]   rom_idx;
  logic [MAG_W-1:0]   mag;
  logic [SAMPLE_W-1:0] mag_ext;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: enable alone moves between IDLE and RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (enable)  state_d = ST_RUN;
      ST_RUN:  if (!enable) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign run_next = (state_d == ST_RUN);
  assign tick     = (state_q == ST_RUN) && (cnt_q == DIV_M1);
  assign accept   = inc_valid && !pend_vld_q;
  assign inc_eff  = pend_vld_q ? pend_q : inc_active_q;
  assign sum      = {1'b0, acc_q} + {1'b0, inc_eff};

  // Sample address: top accumulator bits; odd quadrants read the table mirrored.
  assign addr    = acc_q[PHASE_W-1 -: ADDR_W];
  assign rom_idx = addr[IDX_W] ? ~addr[IDX_W-1:0] : addr[IDX_W-1:0];

  // Divider, accumulator and increment handshake.
  always_comb begin
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    carry_d      = carry_q;
    inc_active_d = inc_active_q;
    pend_d       = pend_q;
    pend_vld_d   = pend_vld_q;
    s1_vld_d     = 1'b0;
    s1_neg_d     = s1_neg_q;
    s1_wrap_d    = s1_wrap_q;

    if (state_q == ST_IDLE) begin
      cnt_d = '0;
      if (accept) begin
        inc_active_d = fase_inc;
      end
    end else begin
      cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
      if (tick) begin
        // wrap marks the sample addressed after an overflowing step,
        // i.e. the carry left by the previous tick.
        s1_vld_d     = 1'b1;
        s1_neg_d     = addr[ADDR_W-1];
        s1_wrap_d    = carry_q;
        acc_d        = sum[PHASE_W-1:0];
        carry_d      = sum[PHASE_W];
        inc_active_d = inc_eff;
        pend_vld_d   = 1'b0;
      end
      if (accept) begin
        pend_d     = fase_inc;
        pend_vld_d = 1'b1;
      end
    end

    // Leaving or staying in IDLE restarts the phase and drops in-flight
    // samples; the pending increment is kept.
    if (!run_next) begin
      cnt_d    = '0;
      acc_d    = '0;
      carry_d  = 1'b0;
      s1_vld_d = 1'b0;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q        <= '0;
      acc_q        <= '0;
      carry_q      <= 1'b0;
      inc_active_q <= '0;
      pend_q       <= '0;
      pend_vld_q   <= 1'b0;
      s1_vld_q     <= 1'b0;
      s1_neg_q     <= 1'b0;
      s1_wrap_q    <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      carry_q      <= carry_d;
      inc_active_q <= inc_active_d;
      pend_q       <= pend_d;
      pend_vld_q   <= pend_vld_d;
      s1_vld_q     <= s1_vld_d;
      s1_neg_q     <= s1_neg_d;
      s1_wrap_q    <= s1_wrap_d;
    end
  end

  tabela_seno u_tabela (
    .clk   (clk),
    .reset (reset),
    .rd_en (tick),
    .idx   (rom_idx),
    .mag   (mag)
  );

  assign mag_ext = SAMPLE_W'(mag);

  // Output stage: apply the sign, raise the strobes, zero everything in IDLE.
  always_comb begin
    saida_d  = saida_q;
    pronta_d = 1'b0;
    wrap_d   = 1'b0;
    if (!run_next) begin
      saida_d = '0;
    end else if (s1_vld_q) begin
      saida_d  = s1_neg_q ? -$signed(mag_ext) : $signed(mag_ext);
      pronta_d = 1'b1;
      wrap_d   = s1_wrap_q;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      saida_q  <= '0;
      pronta_q <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      saida_q  <= saida_d;
      pronta_q <= pronta_d;
      wrap_q   <= wrap_d;
    end
  end

  assign saida          = saida_q;
  assign amostra_pronta = pronta_q;
  assign wrap           = wrap_q;
  assign inc_ready      = !pend_vld_q;
  assign estado_dbg     = state_q;

endmodule

// File: tb/tb_gerador_tom.sv
// Directed bench for gerador_tom (CLK_DIV=4, PHASE_W=24) with a sample scoreboard.
module tb_gerador_tom;
  import gerador_pkg::*;

  localparam int CLK_DIV = 4;
  localparam int PW      = 24;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0;
  logic [PW-1:0] fase_inc = '0;
  logic          inc_valid = 1'b0;
  logic          inc_ready;
  logic signed [11:0] saida;
  logic          amostra_pronta;
  logic          wrap;
  estado_e       estado_dbg;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int mark_cyc = 0;
  int last_strobe_cyc = 0;

  // {gap[7:0], wrap, saida[11:0]}; gap 0 = interval not checked
  logic [20:0] exp_q[$];

  gerador_tom #(.CLK_DIV(CLK_DIV), .PHASE_W(PW)) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .fase_inc       (fase_inc),
    .inc_valid      (inc_valid),
    .inc_ready      (inc_ready),
    .saida          (saida),
    .amostra_pronta (amostra_pronta),
    .wrap           (wrap),
    .estado_dbg     (estado_dbg)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic void push_exp(input int s, input bit w, input int gap);
    logic [11:0] s12;
    logic [7:0]  g8;
    s12 = 12'(s);
    g8  = 8'(gap);
    exp_q.push_back({g8, w, s12});
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (amostra_pronta) begin
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", 1, 0);
      end else begin
        check("saida", int'(saida), int'($signed(exp_q[0][11:0])));
        check("wrap", int'(wrap), int'(exp_q[0][12]));
        if (exp_q[0][20:13] != 8'd0)
          check("strobe_gap",
                cyc - ((mark_cyc > last_strobe_cyc) ? mark_cyc : last_strobe_cyc),
                int'(exp_q[0][20:13]));
        void'(exp_q.pop_front());
      end
      last_strobe_cyc <= cyc;
    end else begin
      check("wrap_without_strobe", int'(wrap), 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer_inc(input logic [PW-1:0] v);
    fase_inc  = v;
    inc_valid = 1'b1;
    step();
    inc_valid = 1'b0;
  endtask

  task automatic start_run();
    enable   = 1'b1;
    mark_cyc = cyc;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    check("drain", exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Drop enable one clock after the tick that follows a drained strobe.
  task automatic disable_after_tick(input string tag);
    step();
    step();
    enable = 1'b0;
    step();
    check({tag, "_saida"}, int'(saida), 0);
    check({tag, "_pronta"}, int'(amostra_pronta), 0);
    check({tag, "_state"}, int'(estado_dbg), int'(ST_IDLE));
    repeat (6) step();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) step();
    check("rst_saida", int'(saida), 0);
    check("rst_pronta", int'(amostra_pronta), 0);
    check("rst_wrap", int'(wrap), 0);
    check("rst_ready", int'(inc_ready), 1);
    check("rst_state", int'(estado_dbg), int'(ST_IDLE));
    reset = 1'b1;
    step();

    // 2^22 loaded in IDLE: address steps by 256, one quadrant per sample
    check("idle_ready", int'(inc_ready), 1);
    offer_inc(24'h400000);
    check("idle_ready_after", int'(inc_ready), 1);
    check("idle_saida", int'(saida), 0);
    push_exp(6, 0, 6);
    push_exp(2047, 0, 4); push_exp(-6, 0, 4); push_exp(-2047, 0, 4);
    push_exp(6, 1, 4); push_exp(2047, 0, 4); push_exp(-6, 0, 4); push_exp(-2047, 0, 4);
    push_exp(6, 1, 4); push_exp(2047, 0, 4); push_exp(-6, 0, 4); push_exp(-2047, 0, 4);
    push_exp(6, 1, 4);
    start_run();
    wait_drain(80);
    disable_after_tick("dis1");

    // Re-enable: phase restarts at 0, increment kept
    push_exp(6, 0, 6); push_exp(2047, 0, 4); push_exp(-6, 0, 4);
    push_exp(-2047, 0, 4); push_exp(6, 1, 4);
    start_run();
    wait_drain(60);

    // Reset between tick and strobe
    step();
    step();
    check("pre_rst_saida", int'(saida), 6);
    #2 reset = 1'b0;
    #1;
    check("arst_saida", int'(saida), 0);
    check("arst_pronta", int'(amostra_pronta), 0);
    check("arst_wrap", int'(wrap), 0);
    check("arst_ready", int'(inc_ready), 1);
    check("arst_state", int'(estado_dbg), int'(ST_IDLE));
    enable = 1'b0;
    repeat (4) step();
    reset = 1'b1;
    step();

    // fase_inc = 0: constant 6, no wrap
    offer_inc(24'h000000);
    push_exp(6, 0, 6); push_exp(6, 0, 4); push_exp(6, 0, 4); push_exp(6, 0, 4);
    start_run();
    wait_drain(60);

    // 2^20 offered in RUN: held pending until the next tick, then step 64
    check("run_ready", int'(inc_ready), 1);
    push_exp(6, 0, 4); push_exp(789, 0, 4); push_exp(1452, 0, 4);
    push_exp(1894, 0, 4); push_exp(2047, 0, 4);
    offer_inc(24'h100000);
    check("run_ready_low", int'(inc_ready), 0);
    fase_inc  = 24'h123456;
    inc_valid = 1'b1;
    step();
    inc_valid = 1'b0;
    check("run_ready_back", int'(inc_ready), 1);
    wait_drain(60);
    disable_after_tick("dis2");

    // 2^23: alternating half periods, wrap on every first half
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
    offer_inc(24'h800000);
    push_exp(6, 0, 6); push_exp(-6, 0, 4); push_exp(6, 1, 4); push_exp(-6, 0, 4);
    push_exp(6, 1, 4); push_exp(-6, 0, 4); push_exp(6, 1, 4);
    start_run();
    wait_drain(60);
    enable = 1'b0;
    repeat (8) step();

    check("final_queue", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
